// File: rtl/pe_tile_pkg.sv
// Shared constants for the parametrised PE tile: opcodes, config register
// indices and the bit layout of the PE control register.
package pe_tile_pkg;

  typedef enum logic [2:0] {
    PE_ADD    = 3'd0,
    PE_SUB    = 3'd1,
    PE_AND    = 3'd2,
    PE_OR     = 3'd3,
    PE_XOR    = 3'd4,
    PE_PASS_A = 3'd5,
    PE_PASS_B = 3'd6,
    PE_ZERO   = 3'd7
  } pe_op_e;

  // Config register indices (low half of config_addr). The SB block starts
  // at SB_BASE and holds one entry per output slice; it must stay below OP0_SEL.
  localparam logic [15:0] SB_BASE = 16'h0000;
  localparam logic [15:0] OP0_SEL = 16'h0040;
  localparam logic [15:0] OP1_SEL = 16'h0041;
  localparam logic [15:0] PE_CTRL = 16'h0042;

  // PE control register layout.
  localparam int CTRL_W      = 5;
  localparam int CTRL_OP_LSB = 0;
  localparam int CTRL_OP_W   = 3;
  localparam int CTRL_BYPASS = 3;
  localparam int CTRL_ACCUM  = 4;

  // Switch-box select width.
  localparam int SB_SEL_W = 2;

endpackage

// File: rtl/pe_tile_alu.sv
// Combinational PE arithmetic/logic unit. All arithmetic wraps modulo
// 2^WIDTH; there is no carry or borrow output.
module pe_tile_alu
  import pe_tile_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  // Opcode decode; sums and differences truncate to WIDTH bits.
  always_comb begin
    result = '0;
    case (pe_op_e'(opcode))
      PE_ADD:    result = a + b;
      PE_SUB:    result = a - b;
      PE_AND:    result = a & b;
      PE_OR:     result = a | b;
      PE_XOR:    result = a ^ b;
      PE_PASS_A: result = a;
      PE_PASS_B: result = b;
      PE_ZERO:   result = '0;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/pe_tile_param.sv
// Parametrised PE tile: switch box, two operand muxes, a PE with optional
// output register and accumulate mode, configured over the tile-addressed
// config bus with registered readback.
module pe_tile_param
  import pe_tile_pkg::*;
#(
  parameter int WIDTH      = 1,
  parameter int NUM_TRACKS = 4,
  parameter int NUM_SIDES  = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [15:0]                           tile_id,
  input  logic [31:0]                           config_addr,
  input  logic [31:0]                           config_data,
  input  logic                                  config_en,
  input  logic                                  config_we,
  output logic [31:0]                           config_rd_data,
  output logic                                  config_rd_valid,
  input  logic [NUM_SIDES*NUM_TRACKS*WIDTH-1:0] in_wires,
  output logic [NUM_SIDES*NUM_TRACKS*WIDTH-1:0] out_wires,
  output logic [WIDTH-1:0]                      pe_out
);

  localparam int NUM_K    = NUM_SIDES * NUM_TRACKS;
  localparam int OP_SEL_W = (NUM_K > 1) ? $clog2(NUM_K) : 1;

  logic [SB_SEL_W-1:0] sb_sel_q [NUM_K];
  logic [SB_SEL_W-1:0] sb_sel_d [NUM_K];
  logic [OP_SEL_W-1:0] op0_sel_q, op0_sel_d;
  logic [OP_SEL_W-1:0] op1_sel_q, op1_sel_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [WIDTH-1:0]    pe_out_q, pe_out_d;
  logic [31:0]         rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;

  logic                cfg_hit;
  logic [15:0]         cfg_idx;
  logic [WIDTH-1:0]    in_slice [NUM_K];
  logic [WIDTH-1:0]    sb_out [NUM_K];
  logic [WIDTH-1:0]    op0, op1, alu_a, alu_result;
  logic [2:0]          ctrl_opcode;
  logic                ctrl_bypass, ctrl_accum;
  logic                unused_cfg_data;

  // Only the low bits of config_data are stored; the rest is deliberately dropped.
  assign unused_cfg_data = ^config_data;

  for (genvar gi = 0; gi < NUM_K; gi++) begin : g_slice
    assign in_slice[gi]                   = in_wires[gi*WIDTH +: WIDTH];
    assign out_wires[gi*WIDTH +: WIDTH]   = sb_out[gi];
  end

  assign cfg_hit = config_en && (config_addr[31:16] == tile_id);
  assign cfg_idx = config_addr[15:0];

  // Config register writes and readback mux for accesses addressed to this tile.
  always_comb begin
    sb_sel_d   = sb_sel_q;
    op0_sel_d  = op0_sel_q;
    op1_sel_d  = op1_sel_q;
    ctrl_d     = ctrl_q;
    rd_valid_d = 1'b0;
    rd_data_d  = '0;
    if (cfg_hit && config_we) begin
      for (int k = 0; k < NUM_K; k++) begin
        if (cfg_idx == SB_BASE + 16'(k)) sb_sel_d[k] = config_data[SB_SEL_W-1:0];
      end
      if (cfg_idx == OP0_SEL) op0_sel_d = config_data[OP_SEL_W-1:0];
      if (cfg_idx == OP1_SEL) op1_sel_d = config_data[OP_SEL_W-1:0];
      if (cfg_idx == PE_CTRL) ctrl_d    = config_data[CTRL_W-1:0];
    end else if (cfg_hit) begin
      rd_valid_d = 1'b1;
      for (int k = 0; k < NUM_K; k++) begin
        if (cfg_idx == SB_BASE + 16'(k)) rd_data_d = 32'(sb_sel_q[k]);
      end
      if (cfg_idx == OP0_SEL) rd_data_d = 32'(op0_sel_q);
      if (cfg_idx == OP1_SEL) rd_data_d = 32'(op1_sel_q);
      if (cfg_idx == PE_CTRL) rd_data_d = 32'(ctrl_q);
    end
  end

  // Operand muxes; out-of-range selects fall back to slice 0.
  always_comb begin
    op0 = in_slice[0];
    op1 = in_slice[0];
    for (int k = 1; k < NUM_K; k++) begin
      if (int'(op0_sel_q) == k) op0 = in_slice[k];
      if (int'(op1_sel_q) == k) op1 = in_slice[k];
    end
  end

  // Switch box: select v < NUM_SIDES-1 picks side (s+1+v) mod NUM_SIDES on the
  // same track, NUM_SIDES-1 picks the PE output, anything larger decodes as 0.
  always_comb begin
    for (int s = 0; s < NUM_SIDES; s++) begin
      for (int t = 0; t < NUM_TRACKS; t++) begin
        sb_out[s*NUM_TRACKS+t] = in_slice[((s + 1) % NUM_SIDES)*NUM_TRACKS + t];
        for (int v = 1; v < NUM_SIDES - 1; v++) begin
          if (int'(sb_sel_q[s*NUM_TRACKS+t]) == v)
            sb_out[s*NUM_TRACKS+t] = in_slice[((s + 1 + v) % NUM_SIDES)*NUM_TRACKS + t];
        end
        if (int'(sb_sel_q[s*NUM_TRACKS+t]) == NUM_SIDES - 1)
          sb_out[s*NUM_TRACKS+t] = pe_out;
      end
    end
  end

  assign ctrl_opcode = ctrl_q[CTRL_OP_LSB +: CTRL_OP_W];
  assign ctrl_bypass = ctrl_q[CTRL_BYPASS];
  assign ctrl_accum  = ctrl_q[CTRL_ACCUM];

  // Accumulate feeds the registered result back as operand A.
  assign alu_a = ctrl_accum ? pe_out_q : op0;

  pe_tile_alu #(.WIDTH(WIDTH)) u_alu (
    .opcode (ctrl_opcode),
    .a      (alu_a),
    .b      (op1),
    .result (alu_result)
  );

  // The output register samples the ALU every cycle; bypass is overridden by accumulate.
  always_comb begin
    pe_out_d = alu_result;
    pe_out   = (ctrl_bypass && !ctrl_accum) ? alu_result : pe_out_q;
  end

  assign config_rd_data  = rd_data_q;
  assign config_rd_valid = rd_valid_q;

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_K; k++) sb_sel_q[k] <= SB_SEL_W'(NUM_SIDES - 1);
      op0_sel_q  <= '0;
      op1_sel_q  <= '0;
      ctrl_q     <= '0;
      pe_out_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      sb_sel_q   <= sb_sel_d;
      op0_sel_q  <= op0_sel_d;
      op1_sel_q  <= op1_sel_d;
      ctrl_q     <= ctrl_d;
      pe_out_q   <= pe_out_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule

// File: tb/tb_pe_tile_param.sv
// Self-checking bench for pe_tile_param: an 8-bit tile and a 4-bit tile share
// the clock, reset and config bus but answer to different tile ids.
module tb_pe_tile_param;

  localparam logic [15:0] TILE8 = 16'h0012;
  localparam logic [15:0] TILE4 = 16'h0034;
  localparam logic [15:0] TILEX = 16'h0099;
  localparam logic [15:0] IDX_OP0  = 16'h0040;
  localparam logic [15:0] IDX_OP1  = 16'h0041;
  localparam logic [15:0] IDX_CTRL = 16'h0042;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  config_addr, config_data;
  logic         config_en, config_we;
  logic [127:0] in8, out8;
  logic [63:0]  in4, out4;
  logic [7:0]   pe8;
  logic [3:0]   pe4;
  logic [31:0]  rd8, rd4;
  logic         v8, v4;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected configuration of the 8-bit tile
  int m8_sb [16];
  int m8_op0, m8_op1, m8_ctrl;

  always #5 clk = ~clk;

  pe_tile_param #(.WIDTH(8), .NUM_TRACKS(4), .NUM_SIDES(4)) u_dut8 (
    .clk(clk), .reset(reset), .tile_id(TILE8),
    .config_addr(config_addr), .config_data(config_data),
    .config_en(config_en), .config_we(config_we),
    .config_rd_data(rd8), .config_rd_valid(v8),
    .in_wires(in8), .out_wires(out8), .pe_out(pe8)
  );

  pe_tile_param #(.WIDTH(4), .NUM_TRACKS(4), .NUM_SIDES(4)) u_dut4 (
    .clk(clk), .reset(reset), .tile_id(TILE4),
    .config_addr(config_addr), .config_data(config_data),
    .config_en(config_en), .config_we(config_we),
    .config_rd_data(rd4), .config_rd_valid(v4),
    .in_wires(in4), .out_wires(out4), .pe_out(pe4)
  );

  // Reference PE: opcode semantics with plain integer arithmetic mod 2^w.
  function automatic int ref_pe(int op, int a, int b, int w);
    int m;
    m = 1 << w;
    case (op)
      0: return (a + b) % m;
      1: return (a - b + m) % m;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a;
      6: return b;
      default: return 0;
    endcase
  endfunction

  function automatic int get8(int k);
    return int'(in8[k*8 +: 8]);
  endfunction

  task automatic cfg_write(input logic [15:0] tile, input logic [15:0] idx, input logic [31:0] data);
    @(negedge clk);
    config_addr = {tile, idx};
    config_data = data;
    config_en   = 1'b1;
    config_we   = 1'b1;
    @(negedge clk);
    config_en   = 1'b0;
    config_we   = 1'b0;
    $display("[TB] write tile=%h idx=%h data=%h", tile, idx, data);
  endtask

  // Returns read data/valid one cycle after the strobe, and valid one cycle later.
  task automatic cfg_read(input logic [15:0] tile, input logic [15:0] idx,
                          output logic [31:0] d8, output logic a8, output logic b8,
                          output logic [31:0] d4, output logic a4, output logic b4);
    @(negedge clk);
    config_addr = {tile, idx};
    config_data = 32'h0;
    config_en   = 1'b1;
    config_we   = 1'b0;
    @(negedge clk);
    config_en   = 1'b0;
    d8 = rd8; a8 = v8; d4 = rd4; a4 = v4;
    @(negedge clk);
    b8 = v8; b4 = v4;
    $display("[TB] read  tile=%h idx=%h rd8=%h/%0b rd4=%h/%0b", tile, idx, d8, a8, d4, a4);
  endtask

  task automatic test_reset();
    logic [31:0] d8, d4;
    logic a8, b8, a4, b4;
    in8 = {$urandom, $urandom, $urandom, $urandom};
    in4 = {$urandom, $urandom};
    #1;
    n_tests++; if (out8 !== '0) begin n_fail++; $display("FAIL rst_out8: got %h expected 0", out8); end
    n_tests++; if (pe8 !== 8'h0) begin n_fail++; $display("FAIL rst_pe8: got %h expected 0", pe8); end
    n_tests++; if (out4 !== '0) begin n_fail++; $display("FAIL rst_out4: got %h expected 0", out4); end
    n_tests++; if (v8 !== 1'b0 || rd8 !== 32'h0) begin n_fail++; $display("FAIL rst_rd8: got %h/%b expected 0/0", rd8, v8); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++; if (out8 !== '0 || pe8 !== 8'h0) begin n_fail++; $display("FAIL rel_out8: got %h/%h expected 0/0", out8, pe8); end
    for (int k = 0; k < 16; k++) m8_sb[k] = 3;
    m8_op0 = 0; m8_op1 = 0; m8_ctrl = 0;
    cfg_read(TILE8, IDX_CTRL, d8, a8, b8, d4, a4, b4);
    n_tests++; if (d8 !== 32'h0) begin n_fail++; $display("FAIL rst_ctrl: got %h expected 0", d8); end
    n_tests++; if (a8 !== 1'b1) begin n_fail++; $display("FAIL rd_valid: got %b expected 1", a8); end
    n_tests++; if (b8 !== 1'b0) begin n_fail++; $display("FAIL rd_valid_pulse: got %b expected 0", b8); end
    n_tests++; if (a4 !== 1'b0) begin n_fail++; $display("FAIL other_tile_valid: got %b expected 0", a4); end
    cfg_read(TILE8, 16'h0003, d8, a8, b8, d4, a4, b4);
    n_tests++; if (d8 !== 32'd3) begin n_fail++; $display("FAIL rst_sb3: got %h expected 3", d8); end
  endtask

  task automatic test_add_bypass();
    in8 = '0;
    in8[0 +: 8]   = 8'd200;
    in8[5*8 +: 8] = 8'd100;
    cfg_write(TILE8, IDX_OP0, 32'd0);
    cfg_write(TILE8, IDX_OP1, 32'd5);
    cfg_write(TILE8, IDX_CTRL, 32'd0);
    m8_op0 = 0; m8_op1 = 5; m8_ctrl = 0;
    n_tests++; if (pe8 !== 8'd44) begin n_fail++; $display("FAIL add_reg: got %0d expected 44", pe8); end
    in8[0 +: 8] = 8'd1;
    #1;
    n_tests++; if (pe8 !== 8'd44) begin n_fail++; $display("FAIL add_hold: got %0d expected 44", pe8); end
    @(negedge clk);
    n_tests++; if (pe8 !== 8'd101) begin n_fail++; $display("FAIL add_next: got %0d expected 101", pe8); end
    cfg_write(TILE8, IDX_CTRL, 32'h08);
    m8_ctrl = 8;
    in8[0 +: 8]   = 8'd200;
    in8[5*8 +: 8] = 8'd100;
    #1;
    n_tests++; if (pe8 !== 8'd44) begin n_fail++; $display("FAIL bypass_44: got %0d expected 44", pe8); end
    in8[5*8 +: 8] = 8'd50;
    #1;
    n_tests++; if (pe8 !== 8'd250) begin n_fail++; $display("FAIL bypass_250: got %0d expected 250", pe8); end
  endtask

  task automatic test_pe_random();
    int op, s0, s1, byp, cv, exp;
    for (int i = 0; i < 16; i++) begin
      op  = int'($urandom_range(0, 7));
      s0  = int'($urandom_range(0, 15));
      s1  = int'($urandom_range(0, 15));
      byp = int'($urandom_range(0, 1));
      cv  = (byp << 3) | op;
      in8 = {$urandom, $urandom, $urandom, $urandom};
      cfg_write(TILE8, IDX_OP0, ($urandom & 32'hFFFF_FFF0) | 32'(s0));
      cfg_write(TILE8, IDX_OP1, ($urandom & 32'hFFFF_FFF0) | 32'(s1));
      cfg_write(TILE8, IDX_CTRL, ($urandom & 32'hFFFF_FFE0) | 32'(cv));
      m8_op0 = s0; m8_op1 = s1; m8_ctrl = cv;
      @(negedge clk);
      exp = ref_pe(op, get8(s0), get8(s1), 8);
      n_tests++;
      if (pe8 !== 8'(exp)) begin
        n_fail++;
        $display("FAIL pe_rand op=%0d s0=%0d s1=%0d byp=%0d: got %0d expected %0d", op, s0, s1, byp, pe8, exp);
      end
    end
  endtask

  task automatic test_sb();
    int kp, sel, exp, k;
    kp = int'($urandom_range(0, 15));
    cfg_write(TILE8, IDX_OP0, 32'(kp));
    cfg_write(TILE8, IDX_CTRL, 32'h0D);
    m8_op0 = kp; m8_ctrl = 13;
    for (int j = 0; j < 16; j++) begin
      sel = int'($urandom_range(0, 3));
      cfg_write(TILE8, 16'(j), ($urandom & 32'hFFFF_FFFC) | 32'(sel));
      m8_sb[j] = sel;
    end
    for (int rep = 0; rep < 3; rep++) begin
      in8 = {$urandom, $urandom, $urandom, $urandom};
      #1;
      for (int s = 0; s < 4; s++) begin
        for (int t = 0; t < 4; t++) begin
          k   = s*4 + t;
          exp = (m8_sb[k] == 3) ? get8(kp) : get8(((s + 1 + m8_sb[k]) % 4)*4 + t);
          n_tests++;
          if (out8[k*8 +: 8] !== 8'(exp)) begin
            n_fail++;
            $display("FAIL sb_out k=%0d sel=%0d: got %0d expected %0d", k, m8_sb[k], out8[k*8 +: 8], exp);
          end
        end
      end
    end
    cfg_write(TILE8, 16'h0000, 32'd1);
    m8_sb[0] = 1;
    in8 = {$urandom, $urandom, $urandom, $urandom};
    #1;
    n_tests++; if (out8[7:0] !== in8[8*8 +: 8]) begin n_fail++; $display("FAIL sb_side2: got %0d expected %0d", out8[7:0], in8[8*8 +: 8]); end
    cfg_write(TILE8, 16'h0000, 32'd3);
    m8_sb[0] = 3;
    in8[kp*8 +: 8] = 8'(($urandom_range(0, 255)));
    #1;
    n_tests++; if (out8[7:0] !== 8'(get8(kp))) begin n_fail++; $display("FAIL sb_pe: got %0d expected %0d", out8[7:0], get8(kp)); end
  endtask

  task automatic test_mismatch();
    logic [31:0] d8, d4;
    logic a8, b8, a4, b4;
    cfg_write(TILE8, IDX_CTRL, 32'h06);
    m8_ctrl = 6;
    cfg_write(TILEX, IDX_CTRL, 32'h05);
    cfg_write(TILEX, 16'h0001, 32'h0);
    cfg_read(TILE8, IDX_CTRL, d8, a8, b8, d4, a4, b4);
    n_tests++; if (d8 !== 32'h06) begin n_fail++; $display("FAIL miss_wr8: got %h expected 6", d8); end
    cfg_read(TILE4, IDX_CTRL, d8, a8, b8, d4, a4, b4);
    n_tests++; if (d4 !== 32'h0 || a4 !== 1'b1) begin n_fail++; $display("FAIL miss_wr4: got %h/%b expected 0/1", d4, a4); end
    cfg_read(TILEX, IDX_CTRL, d8, a8, b8, d4, a4, b4);
    n_tests++; if (a8 !== 1'b0 || b8 !== 1'b0) begin n_fail++; $display("FAIL miss_rd8: got %b%b expected 00", a8, b8); end
    n_tests++; if (a4 !== 1'b0 || b4 !== 1'b0) begin n_fail++; $display("FAIL miss_rd4: got %b%b expected 00", a4, b4); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d8, d4;
    logic a8, b8, a4, b4;
    logic [15:0] gaps [3];
    gaps[0] = 16'h007F; gaps[1] = 16'h0010; gaps[2] = 16'h0043;
    cfg_write(TILE8, 16'h007F, $urandom);
    foreach (gaps[g]) begin
      cfg_read(TILE8, gaps[g], d8, a8, b8, d4, a4, b4);
      n_tests++;
      if (d8 !== 32'h0 || a8 !== 1'b1) begin
        n_fail++;
        $display("FAIL unmapped idx=%h: got %h/%b expected 0/1", gaps[g], d8, a8);
      end
    end
    cfg_read(TILE8, IDX_OP0, d8, a8, b8, d4, a4, b4);
    n_tests++; if (d8 !== 32'(m8_op0)) begin n_fail++; $display("FAIL keep_op0: got %h expected %h", d8, m8_op0); end
    cfg_read(TILE8, IDX_OP1, d8, a8, b8, d4, a4, b4);
    n_tests++; if (d8 !== 32'(m8_op1)) begin n_fail++; $display("FAIL keep_op1: got %h expected %h", d8, m8_op1); end
    cfg_read(TILE8, IDX_CTRL, d8, a8, b8, d4, a4, b4);
    n_tests++; if (d8 !== 32'(m8_ctrl)) begin n_fail++; $display("FAIL keep_ctrl: got %h expected %h", d8, m8_ctrl); end
    for (int j = 0; j < 16; j++) begin
      cfg_read(TILE8, 16'(j), d8, a8, b8, d4, a4, b4);
      n_tests++;
      if (d8 !== 32'(m8_sb[j])) begin n_fail++; $display("FAIL keep_sb%0d: got %h expected %h", j, d8, m8_sb[j]); end
    end
  endtask

  task automatic test_accum();
    logic [31:0] d8, d4;
    logic a8, b8, a4, b4;
    int acc;
    in4 = '0;
    in4[5*4 +: 4] = 4'd3;
    cfg_write(TILE4, IDX_CTRL, 32'h10);
    cfg_write(TILE4, IDX_OP1, 32'd5);
    acc = 0;
    n_tests++; if (pe4 !== 4'd0) begin n_fail++; $display("FAIL acc_start: got %0d expected 0", pe4); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      acc = (acc + 3) % 16;
      n_tests++;
      if (pe4 !== 4'(acc)) begin n_fail++; $display("FAIL acc_step%0d: got %0d expected %0d", i, pe4, acc); end
    end
    #2 reset = 1'b0;
    #1;
    n_tests++; if (pe4 !== 4'd0 || out4 !== '0) begin n_fail++; $display("FAIL acc_reset: got %0d/%h expected 0/0", pe4, out4); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++; if (pe4 !== 4'd0) begin n_fail++; $display("FAIL acc_release: got %0d expected 0", pe4); end
    cfg_read(TILE4, IDX_CTRL, d8, a8, b8, d4, a4, b4);
    n_tests++; if (d4 !== 32'h0 || a4 !== 1'b1) begin n_fail++; $display("FAIL acc_ctrl_clr: got %h/%b expected 0/1", d4, a4); end
    cfg_read(TILE4, IDX_OP1, d8, a8, b8, d4, a4, b4);
    n_tests++; if (d4 !== 32'h0) begin n_fail++; $display("FAIL acc_op1_clr: got %h expected 0", d4); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    config_en   = 1'b0;
    config_we   = 1'b0;
    config_addr = 32'h0;
    config_data = 32'h0;
    in8         = '0;
    in4         = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_add_bypass();
    test_pe_random();
    test_sb();
    test_mismatch();
    test_unmapped();
    test_accum();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
